// File: rtl/core_clock_ctrl.sv
// Run-control clock-enable generator: halt/run-all/round-robin/single-step core_ce plus LED probe view.
// Optional STEP_DEBOUNCE_EN adds a DB_CYCLES stability filter on the synchronised step button.
module core_clock_ctrl #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned DIV_COUNT   = 25000000,
  parameter int unsigned PROBE_WIDTH = 32,
  parameter int unsigned LED_WIDTH   = 4,
  parameter int unsigned SCAN_TICKS  = 4,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned CSEL_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       mode,
  input  logic                             step_btn,
  input  logic                             auto_scan,
  input  logic [CSEL_W-1:0]                core_sel,
  input  logic [NUM_CORES*PROBE_WIDTH-1:0] probe_bus,
  output logic [NUM_CORES-1:0]             core_ce,
  output logic                             tick,
  output logic [LED_WIDTH-1:0]             led,
  output logic [CSEL_W-1:0]                led_core,
  output logic [31:0]                      step_count
);

  localparam int unsigned DivW  = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned ScanW = $clog2(SCAN_TICKS + 1);

  localparam logic [DivW-1:0]   DivLast   = DivW'(DIV_COUNT - 1);
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_TICKS - 1);
  localparam logic [CSEL_W-1:0] CoreLast  = CSEL_W'(NUM_CORES - 1);
  localparam logic [CSEL_W:0]   NumCoresW = (CSEL_W + 1)'(NUM_CORES);

  typedef enum logic [1:0] {
    ModeHalt       = 2'b00,
    ModeRunAll     = 2'b01,
    ModeRoundRobin = 2'b10,
    ModeStep       = 2'b11
  } mode_e;

  logic [DivW-1:0]      div_q;
  logic                 tick_q;
  logic [NUM_CORES-1:0] ce_q, ce_d;
  logic [CSEL_W-1:0]    rr_q, rr_d;
  logic [1:0]           sync_q;
  logic                 prev_q, edge_q;
  logic                 step_lvl;
  logic [31:0]          step_count_q;
  logic [ScanW-1:0]     scan_q, scan_d;
  logic [CSEL_W-1:0]    led_core_q, led_core_d;
  logic [LED_WIDTH-1:0] led_q, probe_sel;
  logic                 div_wrap;

  assign div_wrap = (div_q == DivLast);

  always_comb begin
    ce_d = '0;
    rr_d = rr_q;
    case (mode_e'(mode))
      ModeRunAll: if (div_wrap) ce_d = '1;
      ModeRoundRobin: begin
        if (div_wrap) begin
          ce_d = NUM_CORES'(1) << rr_q;
          rr_d = (rr_q == CoreLast) ? '0 : rr_q + 1'b1;
        end
      end
      ModeStep: if (edge_q) ce_d = '1;
      default: ce_d = '0;
    endcase
  end

  always_comb begin
    scan_d     = scan_q;
    led_core_d = led_core_q;
    if (auto_scan) begin
      if (tick_q) begin
        if (scan_q == ScanLast) begin
          scan_d     = '0;
          led_core_d = (led_core_q == CoreLast) ? '0 : led_core_q + 1'b1;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
    end else begin
      led_core_d = ({1'b0, core_sel} >= NumCoresW) ? CoreLast : core_sel;
    end
  end

  always_comb begin
    probe_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (led_core_q == CSEL_W'(i)) probe_sel = probe_bus[i*PROBE_WIDTH +: LED_WIDTH];
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
  logic [DbW-1:0] db_cnt_q;
  logic           db_q;

  // Level only follows the synchroniser after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (sync_q[1] == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DbW'(DB_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_q     <= sync_q[1];
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign step_lvl = db_q;
`else
  localparam int unsigned unused_db_cycles = DB_CYCLES;
  assign step_lvl = sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      tick_q       <= 1'b0;
      ce_q         <= '0;
      rr_q         <= '0;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      edge_q       <= 1'b0;
      step_count_q <= '0;
      scan_q       <= '0;
      led_core_q   <= '0;
      led_q        <= '0;
    end else begin
      div_q      <= div_wrap ? '0 : div_q + 1'b1;
      tick_q     <= div_wrap;
      ce_q       <= ce_d;
      rr_q       <= rr_d;
      sync_q     <= {sync_q[0], step_btn};
      prev_q     <= step_lvl;
      edge_q     <= step_lvl & ~prev_q;
      scan_q     <= scan_d;
      led_core_q <= led_core_d;
      led_q      <= probe_sel;
      if (ce_q != '0 && step_count_q != '1) step_count_q <= step_count_q + 1'b1;
    end
  end

  assign core_ce    = ce_q;
  assign tick       = tick_q;
  assign led        = led_q;
  assign led_core   = led_core_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Bench for core_clock_ctrl: scoreboard of expected core_ce pulses plus table-driven LED vectors.
// Build with STEP_DEBOUNCE_EN to add the glitch/hold debounce sequence.
module tb_core_clock_ctrl;

  localparam int NC  = 3;
  localparam int DIV = 4;
  localparam int ST  = 2;
  localparam int LW  = 4;
  localparam int PW  = 32;
  localparam int DB  = 8;
  localparam int CW  = 2;
`ifdef STEP_DEBOUNCE_EN
  localparam int StepLat = 3 + DB;
  localparam int HoldCyc = 20;
`else
  localparam int StepLat = 3;
  localparam int HoldCyc = 3;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic             step_btn;
  logic             auto_scan;
  logic [CW-1:0]    core_sel;
  logic [NC*PW-1:0] probe_bus;
  logic [NC-1:0]    core_ce;
  logic             tick;
  logic [LW-1:0]    led;
  logic [CW-1:0]    led_core;
  logic [31:0]      step_count;

  core_clock_ctrl #(
    .NUM_CORES  (NC),
    .DIV_COUNT  (DIV),
    .PROBE_WIDTH(PW),
    .LED_WIDTH  (LW),
    .SCAN_TICKS (ST),
    .DB_CYCLES  (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .step_btn  (step_btn),
    .auto_scan (auto_scan),
    .core_sel  (core_sel),
    .probe_bus (probe_bus),
    .core_ce   (core_ce),
    .tick      (tick),
    .led       (led),
    .led_core  (led_core),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Cycle index: 0 while in reset, n after the n-th edge with reset low.
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    logic [NC-1:0] ce;
  } exp_t;

  typedef struct {
    logic [CW-1:0] sel;
    logic [CW-1:0] exp_core;
    logic [LW-1:0] exp_led;
  } led_vec_t;

  exp_t     sb[$];
  exp_t     mon_e;
  led_vec_t vecs[3];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [NC-1:0] ce);
    exp_t e;
    e.cyc = c;
    e.ce  = ce;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        check("missed_core_ce", 32'(cyc), 32'(mon_e.cyc));
      end
      if (core_ce !== '0) begin
        if (sb.size() == 0) begin
          check("unexpected_core_ce", 32'(core_ce), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("core_ce_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("core_ce_value", 32'(core_ce), 32'(mon_e.ce));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int b0;
    vecs[0] = '{sel: 2'd3, exp_core: 2'd2, exp_led: 4'hC};
    vecs[1] = '{sel: 2'd1, exp_core: 2'd1, exp_led: 4'hB};
    vecs[2] = '{sel: 2'd2, exp_core: 2'd2, exp_led: 4'hC};

    reset     = 1'b1;
    mode      = 2'b01;
    step_btn  = 1'b0;
    auto_scan = 1'b0;
    core_sel  = '0;
    probe_bus = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    cycles(2);
    check("reset_core_ce", 32'(core_ce), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_step_count", step_count, 32'd0);
    check("reset_led", 32'(led), 32'd0);
    check("reset_led_core", 32'(led_core), 32'd0);

    // Run-all: first tick at cycle 4, period 4.
    for (int k = 1; k <= 5; k++) push(4 * k, 3'b111);
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      to(c);
      check("tick", 32'(tick), ((c % DIV) == 0) ? 32'd1 : 32'd0);
    end
    to(21);
    check("step_count_run_all", step_count, 32'd5);
    mode = 2'b00;

    // Round-robin, then halt and resume: pointer must survive the halt.
    to(23);
    mode = 2'b10;
    push(24, 3'b001);
    push(28, 3'b010);
    push(32, 3'b100);
    push(36, 3'b001);
    to(37);
    mode = 2'b00;
    to(41);
    mode = 2'b10;
    push(44, 3'b010);
    to(45);
    mode = 2'b11;

    // Single-step: two presses, ticks must not produce pulses.
    to(50);
    step_btn = 1'b1;
    push(51 + StepLat, 3'b111);
    to(50 + HoldCyc);
    step_btn = 1'b0;
    to(80);
    step_btn = 1'b1;
    push(81 + StepLat, 3'b111);
    to(80 + HoldCyc);
    step_btn = 1'b0;
    to(111);
    check("step_count_total", step_count, 32'd12);
    mode = 2'b00;

    // Manual LED selection, including the out-of-range clamp.
    foreach (vecs[i]) begin
      core_sel = vecs[i].sel;
      cycles(2);
      check("led_core_manual", 32'(led_core), 32'(vecs[i].exp_core));
      check("led_manual", 32'(led), 32'(vecs[i].exp_led));
    end
    core_sel = 2'd0;
    cycles(1);
    check("led_core_lag", 32'(led_core), 32'd0);
    check("led_lag_old", 32'(led), 32'hC);
    cycles(1);
    check("led_lag_new", 32'(led), 32'hA);

    // Auto-scan: align so the next counted tick is three cycles away.
    while ((cyc % DIV) != 1) cycles(1);
    t1 = cyc;
    auto_scan = 1'b1;
    to(t1 + 7);
    check("scan_hold0", 32'(led_core), 32'd0);
    to(t1 + 8);
    check("scan_core1", 32'(led_core), 32'd1);
    to(t1 + 9);
    check("scan_led1", 32'(led), 32'hB);
    to(t1 + 16);
    check("scan_core2", 32'(led_core), 32'd2);
    to(t1 + 17);
    check("scan_led2", 32'(led), 32'hC);
    to(t1 + 24);
    check("scan_wrap", 32'(led_core), 32'd0);
    to(t1 + 32);
    check("scan_core1_again", 32'(led_core), 32'd1);
    to(t1 + 33);
    reset = 1'b1;
    cycles(1);
    check("midscan_reset_led_core", 32'(led_core), 32'd0);
    check("midscan_reset_led", 32'(led), 32'd0);
    check("midscan_reset_step_count", step_count, 32'd0);
    check("midscan_reset_core_ce", 32'(core_ce), 32'd0);

`ifdef STEP_DEBOUNCE_EN
    cycles(1);
    reset     = 1'b0;
    auto_scan = 1'b0;
    mode      = 2'b11;
    cycles(3);
    step_btn = 1'b1;
    cycles(5);
    step_btn = 1'b0;
    cycles(30);
    b0 = cyc;
    step_btn = 1'b1;
    push(b0 + 1 + StepLat, 3'b111);
    cycles(20);
    step_btn = 1'b0;
    cycles(30);
    check("debounce_step_count", step_count, 32'd1);
`else
    b0 = 0;
    cycles(2);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_clock_ctrl.md
Name: core_clock_ctrl

Overview:
- Parametrised run-control block for the multi-core processor top.
- Replaces the fixed free-running 2 Hz divider with a programmable clock-enable generator. It supports halt, run-all, round-robin and single-step modes for NUM_CORES cores.
- Drives the board LEDs from a selectable or auto-scanned core probe word.
- Cores run on clk and advance only when their core_ce bit is high. There is no derived clock.

Parameters:
- NUM_CORES, 4: number of cores controlled (>=1).
- DIV_COUNT, 25000000: clk cycles per tick (>=2).
- PROBE_WIDTH, 32: width of each core's probe word.
- LED_WIDTH, 4: LED outputs (<= PROBE_WIDTH).
- SCAN_TICKS, 4: ticks each core is shown in auto-scan.
- DB_CYCLES, 1000000: debounce stability window, used only with the optional feature.
- CSEL_W, derived as max(1, clog2(NUM_CORES)): width of core index fields.

Ports:
- clk  in  1  system clock (board E3).
- reset  in  1  synchronous, active-high reset.
- mode  in  2  run mode: 00 halt, 01 run-all, 10 round-robin, 11 single-step.
- step_btn  in  1  asynchronous push button, single-step request.
- auto_scan  in  1  1 = LEDs cycle through cores; 0 = LEDs show core_sel.
- core_sel  in  CSEL_W  manual LED core index.
- probe_bus  in  NUM_CORES*PROBE_WIDTH  core i probe word at bits [i*PROBE_WIDTH +: PROBE_WIDTH].
- core_ce  out  NUM_CORES  per-core clock-enable pulses.
- tick  out  1  one-cycle divider pulse.
- led  out  LED_WIDTH  low LED_WIDTH bits of the displayed core's probe word.
- led_core  out  CSEL_W  index of the displayed core.
- step_count  out  32  number of cycles in which core_ce was non-zero.

Behaviour:
- Reset applies only on a clk rising edge with reset=1. All registers clear to 0: divider, rr_ptr, scan counter, led_core, led, core_ce, tick, step_count, synchroniser, edge detector.
- Divider:
  - Counter runs 0..DIV_COUNT-1 in every mode, including halt, then wraps to 0.
  - tick is registered: high for exactly one cycle, the cycle after counter==DIV_COUNT-1. Period is DIV_COUNT cycles; first tick appears DIV_COUNT cycles after reset release.
- core_ce is registered and asserted for one cycle per event:
  - halt: core_ce stays 0.
  - run-all: core_ce is all ones in the same cycle tick is high.
  - round-robin: in the same cycle tick is high, core_ce is one-hot at bit rr_ptr. rr_ptr then increments and wraps from NUM_CORES-1 to 0. rr_ptr is held across mode changes and reset only by reset.
  - single-step: each accepted step edge gives core_ce all ones for one cycle, two cycles after the edge appears at the second synchroniser flop. Ticks are ignored.
- Step input path:
  - step_btn passes through a 2-flop synchroniser, then rising-edge detection. Edges are detected in all modes but act only in single-step.
  - An edge arriving while a step pulse is in flight is still honoured; pulses are back-to-back allowed.
- Mode changes are sampled each cycle. A tick that coincides with a mode change uses the new mode.
- step_count increments when core_ce != 0 and saturates at 0xFFFFFFFF with no wrap.
- LED display:
  - auto_scan=1: a scan counter counts ticks. When it reaches SCAN_TICKS it clears and led_core advances, wrapping from NUM_CORES-1 to 0.
  - auto_scan=0: led_core <= core_sel, clamped to NUM_CORES-1 when core_sel >= NUM_CORES. The scan counter is held.
  - led <= probe word of led_core, bits [LED_WIDTH-1:0], registered. led lags a led_core change by one cycle.
- With NUM_CORES=1, round-robin behaves as run-all, and led_core stays 0.

Optional Feature:
- Macro STEP_DEBOUNCE_EN.
- Defined: the synchronised step level must hold the same value for DB_CYCLES consecutive clk cycles before the debounced level updates. Edge detection operates on the debounced level, which adds DB_CYCLES cycles of latency. Glitches shorter than DB_CYCLES produce no step.
- Undefined: edge detection operates directly on the synchronised level with no debounce logic, and the DB_CYCLES parameter is unused.

Test Plan (NUM_CORES=3, DIV_COUNT=4, SCAN_TICKS=2, LED_WIDTH=4, DB_CYCLES=8; macro off unless stated):
- Reset release, mode=01 → tick and core_ce=3'b111 every 4th cycle, first at cycle 4. After 5 ticks, step_count=5.
- mode=10 for 4 ticks → core_ce sequence 001, 010, 100, 001. Switch to 00 then back to 10 → next pulse 010.
- mode=11, step_btn pulsed high 3 cycles then low, twice → exactly two core_ce=111 pulses, each 3 cycles after the button rises. No pulses on ticks.
- auto_scan=0, core_sel=3 (out of range), probe words 0xA, 0xB, 0xC → led_core=2, led=4'hC. Set core_sel=0 → led=4'hA one cycle after led_core=0.
- auto_scan=1 → led_core steps 0,1,2,0 every 2 ticks. reset asserted mid-scan → led_core=0, led=0, step_count=0 on the next edge.
- STEP_DEBOUNCE_EN defined: 5-cycle button glitch → no step. Button held 20 cycles → one core_ce=111 pulse.
